// File: rtl/decoder_to_rob_receiver.sv
// decoder_to_rob_receiver: reassembles 4-beat Decoder->ROB packets into one ROB allocation record.
// Define DEC2ROB_RSV_CHECK_EN to drop packets whose beat-1 reserved bits are nonzero and pulse rsv_err.
module decoder_to_rob_receiver (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sop,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_rob_index,
  output logic        out_is_branch,
  output logic        out_is_taken,
  output logic [7:0]  out_op_id,
  output logic [31:0] out_lower_imm,
  output logic [63:0] out_pc,
  output logic        sync_err,
  output logic        rsv_err
);
  typedef enum logic [1:0] {B1, B2, B3, B4} state_t;
  state_t state;
  logic [6:0] stgRobIndex;
  logic stgBranch, stgTaken;
  logic [7:0] stgOpId;
  logic [31:0] stgImm, stgPcHi;
  logic beat, dropRec;
  // Only the final beat stalls, and only while an unconsumed record is held.
  assign in_ready = state != B4 || !out_valid || out_ready;
  assign beat = in_valid && in_ready;
  always_ff @(posedge clk)
    if (rst) begin
      state <= B1;
      stgRobIndex <= '0;
      stgBranch <= 1'b0;
      stgTaken <= 1'b0;
      stgOpId <= '0;
      stgImm <= '0;
      stgPcHi <= '0;
      out_valid <= 1'b0;
      out_rob_index <= '0;
      out_is_branch <= 1'b0;
      out_is_taken <= 1'b0;
      out_op_id <= '0;
      out_lower_imm <= '0;
      out_pc <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= beat && (in_sop ? state != B1 : state == B1);
      if (out_ready) out_valid <= 1'b0;
      if (beat && in_sop) begin
        stgRobIndex <= in_data[31:25];
        stgBranch <= in_data[22];
        stgTaken <= in_data[21];
        stgOpId <= in_data[7:0];
        state <= B2;
      end else if (beat && state == B2) begin
        stgImm <= in_data;
        state <= B3;
      end else if (beat && state == B3) begin
        stgPcHi <= in_data;
        state <= B4;
      end else if (beat && state == B4) begin
        state <= B1;
        if (!dropRec) begin
          out_valid <= 1'b1;
          out_rob_index <= stgRobIndex;
          out_is_branch <= stgBranch;
          out_is_taken <= stgTaken;
          out_op_id <= stgOpId;
          out_lower_imm <= stgImm;
          out_pc <= {stgPcHi, in_data};
        end
      end
    end
`ifdef DEC2ROB_RSV_CHECK_EN
  logic rsvBad;
  // A new beat 1 overwrites the flag, so a resync cancels a pending error.
  always_ff @(posedge clk)
    if (rst) begin
      rsvBad <= 1'b0;
      rsv_err <= 1'b0;
    end else begin
      rsv_err <= beat && !in_sop && state == B4 && rsvBad;
      if (beat && in_sop) rsvBad <= |{in_data[24:23], in_data[20:8]};
    end
  assign dropRec = rsvBad;
`else
  logic unusedRsvBits;
  assign unusedRsvBits = ^{in_data[24:23], in_data[20:8]};
  assign dropRec = 1'b0;
  assign rsv_err = 1'b0;
`endif
endmodule

// File: doc/decoder_to_rob_receiver.md
# decoder_to_rob_receiver

Receiving end of the Decoder→ROB packet channel. Accepts the four 32-bit beats DecoderToRob1..4 from the instruction decoder over a valid/ready link and reassembles them into one ROB allocation record (ROB index, branch flags, operation ID, immediate, 64-bit PC). The record is presented to the Re-Order Buffer write port through an output valid/ready register stage.

## Interface
- No parameters; all widths are fixed by the packet format.
- `clk` in 1: clock, single domain.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decoder beat valid.
- `in_ready` out 1: receiver accepts beat.
- `in_sop` in 1: start of packet; high on beat 1 only.
- `in_data` in 32: packet beat.
- `out_valid` out 1: assembled record valid.
- `out_ready` in 1: ROB accepts record.
- `out_rob_index` out 7: beat1[31:25].
- `out_is_branch` out 1: beat1[22].
- `out_is_taken` out 1: beat1[21].
- `out_op_id` out 8: beat1[7:0].
- `out_lower_imm` out 32: beat2.
- `out_pc` out 64: {beat3, beat4} (upper PC, lower PC).
- `sync_err` out 1: one-cycle pulse on framing error.
- `rsv_err` out 1: one-cycle pulse on reserved-field error (only with `DEC2ROB_RSV_CHECK_EN`).

## Operation
- A beat transfers on `in_valid && in_ready` at a rising edge.
- Collector FSM with states B1, B2, B3, B4, meaning the next beat expected. Reset state is B1.
- B1, beat with `in_sop`=1:
  - Capture beat-1 fields into staging registers.
  - Move to B2.
- B1, beat with `in_sop`=0:
  - Drop the beat.
  - Pulse `sync_err`.
  - Stay in B1.
- B2 / B3, beat with `in_sop`=0:
  - Capture `lower_imm` (in B2) or `upper_pc` (in B3).
  - Advance to B3 or B4.
- B4, beat with `in_sop`=0:
  - Load the output register from staging plus this beat.
  - Set `out_valid`.
  - Return to B1.
- B2/B3/B4, beat with `in_sop`=1 (resync):
  - Abandon the partial packet.
  - Pulse `sync_err`.
  - Treat the beat as a new beat 1 and go to B2. Nothing is output for the abandoned packet.
- `in_ready`:
  - 1 in B1, B2 and B3.
  - In B4, equal to `!out_valid || out_ready`, so a final beat is never accepted while an unconsumed record is held.
  - Combinational from state and output handshake only; never depends on `in_valid`.
- Output register:
  - `out_valid` clears on `out_ready` with no new load in the same cycle.
  - A simultaneous consume and load keeps `out_valid`=1 with the new data.
  - Data is held stable while `out_valid && !out_ready`.
- Reset values:
  - Outputs: `out_valid`=0, all `out_*` data=0, `sync_err`=0, `rsv_err`=0.
  - Internal: state=B1, staging cleared.
  - `in_ready`=1 on the first cycle after reset.
- Reset mid-packet discards the partial packet and any held record without pulsing `sync_err`.

## Timing
- Record latency: `out_valid` rises one cycle after the beat-4 handshake.
- Throughput: one record per 4 cycles sustained when `out_ready`=1 (no bubbles).
- Error pulses are registered: they assert the cycle after the offending beat's handshake, for exactly one cycle.
- Beats 1–3 of the next packet may be accepted while the previous record is still held; only beat 4 stalls.

## Configuration
- Macro `DEC2ROB_RSV_CHECK_EN`.
- Defined:
  - Beat 1 is checked for reserved bits [24:23] and [20:8] all zero.
  - If any is nonzero, the packet is still collected through beat 4 but is not loaded into the output register.
  - `rsv_err` pulses the cycle after the beat-4 handshake.
  - A resync before beat 4 cancels the pending `rsv_err`.
- Not defined:
  - Reserved bits are ignored.
  - `rsv_err` is tied to 0.
  - The checking logic is absent.

## Test plan
- Basic packet:
  - Stimulus: after reset, beats 0x0A600015 (sop), 0x00000100, 0x00000001, 0x80000000 with `out_ready`=1.
  - Required: one cycle after beat 4, `out_valid`=1, `out_rob_index`=5, `out_is_branch`=1, `out_is_taken`=1, `out_op_id`=0x15, `out_lower_imm`=0x100, `out_pc`=0x0000000180000000.
- Back-to-back packets with `in_valid` held high, 8 beats:
  - Required: two records, `out_valid` high on cycle 5 and cycle 9, no `in_ready` deassertion.
- Output stall:
  - Stimulus: `out_ready`=0 while packet 2 arrives.
  - Required: beats 1–3 accepted; `in_ready`=0 in B4 until `out_ready`=1; record 1 data unchanged throughout the stall.
- Framing:
  - Stimulus: `in_sop`=1 on beat 3 of a packet.
  - Required: `sync_err` pulses once, no record for the aborted packet, the following 3 beats complete a correct record.
  - Stimulus: a stray non-sop beat in B1.
  - Required: the beat is dropped and `sync_err` pulses.
- Reset mid-packet:
  - Stimulus: assert `rst` after beat 2.
  - Required: `out_valid`=0, `in_ready`=1, no error pulse; a fresh packet then completes normally.
- With `DEC2ROB_RSV_CHECK_EN` defined:
  - Stimulus: beat 1 = 0x0A800015 (bit 23 set).
  - Required: `rsv_err` pulses after beat 4 and no record is emitted.
  - Without the macro, the same stimulus yields a normal record with `rsv_err`=0.
